// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - region_e     : position class along one raster axis
//   - vga_mode_t   : one complete set of porch/sync/active timing values
//   - VGA_640X480_60 / VGA_800X600_60 : ready-made mode sets
//   - region_total : length of an axis from its four region widths
//   - region_of    : classify a position along an axis
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   typedef enum logic [1:0] {
      RegActive,
      RegFrontPorch,
      RegSync,
      RegBackPorch
   } region_e;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
      logic        hs_pol;
      logic        vs_pol;
   } vga_mode_t;

   localparam vga_mode_t VGA_640X480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      hs_pol:   1'b0, vs_pol: 1'b0
   };

   localparam vga_mode_t VGA_800X600_60 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
      hs_pol:   1'b1, vs_pol: 1'b1
   };

   function automatic int unsigned region_total(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Region order along an axis: active, front porch, sync, back porch.
   function automatic region_e region_of(input int unsigned pos,
                                         input int unsigned active,
                                         input int unsigned fp,
                                         input int unsigned sync);
      if (pos < active) begin
         return RegActive;
      end else if (pos < active + fp) begin
         return RegFrontPorch;
      end else if (pos < active + fp + sync) begin
         return RegSync;
      end else begin
         return RegBackPorch;
      end
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1, parks at
// TOTAL-1 (idle) on reset or stop, and reports the classification of the
// position it is about to take so the top can register outputs with zero
// latency relative to the raster.
// Ports:
//   i_clk, i_clr_n : clock, asynchronous active-low reset
//   i_tick         : advance one position this clk
//   i_stop         : force the idle position (wins over i_tick)
//   o_count        : next-state position (the value the counter loads)
//   o_wrap         : this clk's advance wraps TOTAL-1 -> 0
//   o_active       : next-state position lies in the active region
//   o_sync_next    : sync level (polarity POL applied) for next-state position
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL  = 800,
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter logic        POL    = 1'b0,
   parameter int unsigned CW     = 10
) (
   input  logic          i_clk,
   input  logic          i_clr_n,
   input  logic          i_tick,
   input  logic          i_stop,
   output logic [CW-1:0] o_count,
   output logic          o_wrap,
   output logic          o_active,
   output logic          o_sync_next
);

   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_d;
   logic          w_wrap;
   region_e       w_region;

   always_comb begin
      w_count_d = r_count;
      w_wrap    = 1'b0;
      if (i_stop) begin
         w_count_d = LAST;
      end else if (i_tick) begin
         if (r_count == LAST) begin
            w_count_d = '0;
            w_wrap    = 1'b1;
         end else begin
            w_count_d = r_count + CW'(1);
         end
      end
   end

   always_comb begin
      w_region = region_of(32'(w_count_d), ACTIVE, FP, SYNC);
   end

   assign o_count     = w_count_d;
   assign o_wrap      = w_wrap;
   assign o_active    = (w_region == RegActive);
   assign o_sync_next = (w_region == RegSync) ? POL : ~POL;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_count <= LAST;
      end else begin
         r_count <= w_count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator driven by a pixel clock-enable.
// Every output is a register loaded from the next-state raster position, so
// outputs move on the same edge as the counters and have no combinational
// path from inputs.
// Ports:
//   i_clk, i_clr_n  : system clock, asynchronous active-low reset
//   i_ce            : pixel clock-enable, one raster advance per clk when high
//   i_en            : run enable; low parks the raster at idle and blanks
//   o_hsync/o_vsync : sync outputs, asserted level HS_POL / VS_POL
//   o_video_on      : current pixel is inside the active area
//   o_pixel_x/y     : active-area coordinates, 0 outside the active area
//   o_line_start    : one-clk strobe on the first pixel of each line
//   o_frame_start   : one-clk strobe on the first pixel of each frame
//   o_frame_cnt     : completed-frame count, wraps
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
   parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
   parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
   parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
   parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
   parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
   parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
   parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
   parameter logic        HS_POL   = VGA_640X480_60.hs_pol,
   parameter logic        VS_POL   = VGA_640X480_60.vs_pol,
   parameter int unsigned CW       = 10,
   parameter int unsigned FRAME_W  = 8
) (
   input  logic               i_clk,
   input  logic               i_clr_n,
   input  logic               i_ce,
   input  logic               i_en,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_video_on,
   output logic [CW-1:0]      o_pixel_x,
   output logic [CW-1:0]      o_pixel_y,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic [FRAME_W-1:0] o_frame_cnt
);

   localparam int unsigned H_TOTAL = region_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = region_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       CW == 0 || FRAME_W == 0) begin : g_err_zero
      $error("vga_timing_gen: timing and width parameters must be non-zero");
   end

   if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_err_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter width CW");
   end

   logic          w_tick;
   logic          w_stop;
   logic [CW-1:0] w_hc_next;
   logic [CW-1:0] w_vc_next;
   logic          w_h_wrap;
   logic          w_v_wrap;
   logic          w_h_active;
   logic          w_v_active;
   logic          w_hs_next;
   logic          w_vs_next;

   assign w_tick = i_ce & i_en;
   assign w_stop = ~i_en;

   vga_axis_counter #(
      .TOTAL  (H_TOTAL),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h_axis (
      .i_clk       (i_clk),
      .i_clr_n     (i_clr_n),
      .i_tick      (w_tick),
      .i_stop      (w_stop),
      .o_count     (w_hc_next),
      .o_wrap      (w_h_wrap),
      .o_active    (w_h_active),
      .o_sync_next (w_hs_next)
   );

   vga_axis_counter #(
      .TOTAL  (V_TOTAL),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v_axis (
      .i_clk       (i_clk),
      .i_clr_n     (i_clr_n),
      .i_tick      (w_h_wrap),
      .i_stop      (w_stop),
      .o_count     (w_vc_next),
      .o_wrap      (w_v_wrap),
      .o_active    (w_v_active),
      .o_sync_next (w_vs_next)
   );

   logic               r_hsync,       w_hsync_d;
   logic               r_vsync,       w_vsync_d;
   logic               r_video_on,    w_video_d;
   logic [CW-1:0]      r_pixel_x,     w_pixel_x_d;
   logic [CW-1:0]      r_pixel_y,     w_pixel_y_d;
   logic               r_line_start,  w_line_start_d;
   logic               r_frame_start, w_frame_start_d;
   logic [FRAME_W-1:0] r_frame_cnt,   w_frame_cnt_d;
   // Set once the raster has left idle. The idle position coincides with the
   // last pixel of a frame, so the first advance after reset or a stop also
   // wraps vc; r_run keeps that wrap from being counted as a completed frame.
   logic               r_run,         w_run_d;

   always_comb begin
      w_video_d       = w_h_active & w_v_active;
      w_hsync_d       = w_hs_next;
      w_vsync_d       = w_vs_next;
      w_pixel_x_d     = w_video_d ? w_hc_next : '0;
      w_pixel_y_d     = w_video_d ? w_vc_next : '0;
      w_line_start_d  = w_tick && (w_hc_next == '0);
      w_frame_start_d = w_line_start_d && (w_vc_next == '0);
      w_frame_cnt_d   = r_frame_cnt;
      w_run_d         = r_run;

      if (w_v_wrap && r_run) begin
         w_frame_cnt_d = r_frame_cnt + FRAME_W'(1);
      end
      if (w_tick) begin
         w_run_d = 1'b1;
      end

      // Stopped: blank explicitly rather than relying on idle sitting in the
      // back porch; frame count is held.
      if (w_stop) begin
         w_hsync_d       = ~HS_POL;
         w_vsync_d       = ~VS_POL;
         w_video_d       = 1'b0;
         w_pixel_x_d     = '0;
         w_pixel_y_d     = '0;
         w_line_start_d  = 1'b0;
         w_frame_start_d = 1'b0;
         w_run_d         = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_video_on    <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
         r_run         <= 1'b0;
      end else begin
         r_hsync       <= w_hsync_d;
         r_vsync       <= w_vsync_d;
         r_video_on    <= w_video_d;
         r_pixel_x     <= w_pixel_x_d;
         r_pixel_y     <= w_pixel_y_d;
         r_line_start  <= w_line_start_d;
         r_frame_start <= w_frame_start_d;
         r_frame_cnt   <= w_frame_cnt_d;
         r_run         <= w_run_d;
      end
   end

   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_video_on    = r_video_on;
   assign o_pixel_x     = r_pixel_x;
   assign o_pixel_y     = r_pixel_y;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;
   assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share clock, reset, ce and en: a tiny custom mode (fast
// frames, 3-bit frame counter), the 640x480 default and the 800x600 package
// set. A raster model computes position from the number of advances since the
// last restart using plain division/modulo.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic clk;
   logic clr_n;
   logic ce;
   logic en;

   logic       sm_hs, sm_vs, sm_vid, sm_ls, sm_fs;
   logic [4:0] sm_px, sm_py;
   logic [2:0] sm_fc;
   logic       vg_hs, vg_vs, vg_vid, vg_ls, vg_fs;
   logic [9:0] vg_px, vg_py;
   logic [7:0] vg_fc;
   logic        sv_hs, sv_vs, sv_vid, sv_ls, sv_fs;
   logic [10:0] sv_px, sv_py;
   logic [7:0]  sv_fc;

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL (1'b1), .VS_POL (1'b0), .CW (5), .FRAME_W (3)
   ) u_small (
      .i_clk (clk), .i_clr_n (clr_n), .i_ce (ce), .i_en (en),
      .o_hsync (sm_hs), .o_vsync (sm_vs), .o_video_on (sm_vid),
      .o_pixel_x (sm_px), .o_pixel_y (sm_py),
      .o_line_start (sm_ls), .o_frame_start (sm_fs), .o_frame_cnt (sm_fc)
   );

   vga_timing_gen u_vga (
      .i_clk (clk), .i_clr_n (clr_n), .i_ce (ce), .i_en (en),
      .o_hsync (vg_hs), .o_vsync (vg_vs), .o_video_on (vg_vid),
      .o_pixel_x (vg_px), .o_pixel_y (vg_py),
      .o_line_start (vg_ls), .o_frame_start (vg_fs), .o_frame_cnt (vg_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE (VGA_800X600_60.h_active), .H_FP (VGA_800X600_60.h_fp),
      .H_SYNC (VGA_800X600_60.h_sync), .H_BP (VGA_800X600_60.h_bp),
      .V_ACTIVE (VGA_800X600_60.v_active), .V_FP (VGA_800X600_60.v_fp),
      .V_SYNC (VGA_800X600_60.v_sync), .V_BP (VGA_800X600_60.v_bp),
      .HS_POL (VGA_800X600_60.hs_pol), .VS_POL (VGA_800X600_60.vs_pol),
      .CW (11), .FRAME_W (8)
   ) u_svga (
      .i_clk (clk), .i_clr_n (clr_n), .i_ce (ce), .i_en (en),
      .o_hsync (sv_hs), .o_vsync (sv_vs), .o_video_on (sv_vid),
      .o_pixel_x (sv_px), .o_pixel_y (sv_py),
      .o_line_start (sv_ls), .o_frame_start (sv_fs), .o_frame_cnt (sv_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, fw;
   } bmode_t;

   typedef struct {
      int hs, vs, vid, px, py, ls, fs, fc;
   } obs_t;

   typedef struct {
      bit ce, en;
      int vid, px, py, hs, vs, ls, fs, fc;
   } vec_t;

   bmode_t modes[3];
   string  names[3];
   int     adv;          // advances since last reset / stop
   int     m_fc[3];
   int     m_ls[3];
   int     m_fs[3];
   int     n_err;
   int     n_chk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_pos(input int d, output int hc, output int vc);
      int ht, vt;
      ht = modes[d].ha + modes[d].hf + modes[d].hs + modes[d].hb;
      vt = modes[d].va + modes[d].vf + modes[d].vs + modes[d].vb;
      if (adv == 0) begin
         hc = ht - 1;
         vc = vt - 1;
      end else begin
         hc = (adv - 1) % ht;
         vc = ((adv - 1) / ht) % vt;
      end
   endfunction

   function automatic obs_t model_obs(input int d);
      obs_t   o;
      bmode_t m;
      int     hc, vc;
      m = modes[d];
      model_pos(d, hc, vc);
      o.vid = (hc < m.ha && vc < m.va) ? 1 : 0;
      o.px  = o.vid ? hc : 0;
      o.py  = o.vid ? vc : 0;
      o.hs  = (hc >= m.ha + m.hf && hc < m.ha + m.hf + m.hs) ? m.hp : 1 - m.hp;
      o.vs  = (vc >= m.va + m.vf && vc < m.va + m.vf + m.vs) ? m.vp : 1 - m.vp;
      o.ls  = m_ls[d];
      o.fs  = m_fs[d];
      o.fc  = m_fc[d];
      return o;
   endfunction

   function automatic obs_t get_obs(input int d);
      obs_t o;
      case (d)
         0: begin
            o.hs = int'(sm_hs); o.vs = int'(sm_vs); o.vid = int'(sm_vid);
            o.px = int'(sm_px); o.py = int'(sm_py); o.ls = int'(sm_ls);
            o.fs = int'(sm_fs); o.fc = int'(sm_fc);
         end
         1: begin
            o.hs = int'(vg_hs); o.vs = int'(vg_vs); o.vid = int'(vg_vid);
            o.px = int'(vg_px); o.py = int'(vg_py); o.ls = int'(vg_ls);
            o.fs = int'(vg_fs); o.fc = int'(vg_fc);
         end
         default: begin
            o.hs = int'(sv_hs); o.vs = int'(sv_vs); o.vid = int'(sv_vid);
            o.px = int'(sv_px); o.py = int'(sv_py); o.ls = int'(sv_ls);
            o.fs = int'(sv_fs); o.fc = int'(sv_fc);
         end
      endcase
      return o;
   endfunction

   task automatic model_reset();
      adv = 0;
      for (int d = 0; d < 3; d++) begin
         m_fc[d] = 0;
         m_ls[d] = 0;
         m_fs[d] = 0;
      end
   endtask

   task automatic model_step(input bit c, input bit e);
      int hc, vc;
      if (!e) begin
         adv = 0;
         for (int d = 0; d < 3; d++) begin
            m_ls[d] = 0;
            m_fs[d] = 0;
         end
      end else if (c) begin
         adv++;
         for (int d = 0; d < 3; d++) begin
            model_pos(d, hc, vc);
            m_ls[d] = (hc == 0) ? 1 : 0;
            m_fs[d] = (hc == 0 && vc == 0) ? 1 : 0;
            // Leaving idle is not a completed frame.
            if (m_fs[d] == 1 && adv > 1) m_fc[d] = (m_fc[d] + 1) % (1 << modes[d].fw);
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            m_ls[d] = 0;
            m_fs[d] = 0;
         end
      end
   endtask

   task automatic check_dut(input int d);
      obs_t a, e;
      a = get_obs(d);
      e = model_obs(d);
      chk({names[d], ".hsync"},       a.hs,  e.hs);
      chk({names[d], ".vsync"},       a.vs,  e.vs);
      chk({names[d], ".video_on"},    a.vid, e.vid);
      chk({names[d], ".pixel_x"},     a.px,  e.px);
      chk({names[d], ".pixel_y"},     a.py,  e.py);
      chk({names[d], ".line_start"},  a.ls,  e.ls);
      chk({names[d], ".frame_start"}, a.fs,  e.fs);
      chk({names[d], ".frame_cnt"},   a.fc,  e.fc);
   endtask

   // Inputs change just after a falling edge; outputs are sampled on the next
   // falling edge, half a period after the active edge.
   task automatic step(input bit c, input bit e);
      ce = c;
      en = e;
      @(posedge clk);
      model_step(c, e);
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_dut(d);
   endtask

   initial begin
      vec_t tbl[6];
      int   hs_first, hs_cnt, sv_first, sv_cnt;
      int   sm_ls_cnt, vg_ls_cnt, f_saved, wraps, prev_fc;

      n_err = 0;
      n_chk = 0;
      modes[0] = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 0, 3};
      modes[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
      modes[2] = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 8};
      names[0] = "small";
      names[1] = "vga";
      names[2] = "svga";

      // Small mode, hand-derived: HS_POL=1 (idle 0), VS_POL=0 (idle 1).
      //            ce    en    vid px py hs vs ls fs fc
      tbl[0] = '{1'b1, 1'b1, 1, 0, 0, 0, 1, 1, 1, 0};
      tbl[1] = '{1'b0, 1'b1, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1, 1, 0, 0, 1, 0, 0, 0};
      tbl[3] = '{1'b1, 1'b1, 1, 2, 0, 0, 1, 0, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[5] = '{1'b1, 1'b1, 1, 0, 0, 0, 1, 1, 1, 0};

      // Reset
      clr_n = 1'b0;
      ce    = 1'b0;
      en    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) check_dut(d);
      chk("small.reset_hsync", int'(sm_hs), 0);
      chk("small.reset_vsync", int'(sm_vs), 1);
      chk("vga.reset_hsync", int'(vg_hs), 1);
      chk("svga.reset_vsync", int'(sv_vs), 0);
      clr_n = 1'b1;

      // Table vectors on the small mode
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].ce, tbl[i].en);
         chk($sformatf("tbl%0d.video_on", i), int'(sm_vid), tbl[i].vid);
         chk($sformatf("tbl%0d.pixel_x", i), int'(sm_px), tbl[i].px);
         chk($sformatf("tbl%0d.pixel_y", i), int'(sm_py), tbl[i].py);
         chk($sformatf("tbl%0d.hsync", i), int'(sm_hs), tbl[i].hs);
         chk($sformatf("tbl%0d.vsync", i), int'(sm_vs), tbl[i].vs);
         chk($sformatf("tbl%0d.line_start", i), int'(sm_ls), tbl[i].ls);
         chk($sformatf("tbl%0d.frame_start", i), int'(sm_fs), tbl[i].fs);
         chk($sformatf("tbl%0d.frame_cnt", i), int'(sm_fc), tbl[i].fc);
      end

      // First lines of the 640x480 and 800x600 rasters with ce tied high
      step(1'b0, 1'b0);
      hs_first = -1;
      hs_cnt   = 0;
      sv_first = -1;
      sv_cnt   = 0;
      for (int n = 1; n <= 1100; n++) begin
         step(1'b1, 1'b1);
         if (n == 1) begin
            chk("vga.first_frame_start", int'(vg_fs), 1);
            chk("vga.first_line_start", int'(vg_ls), 1);
            chk("vga.first_video_on", int'(vg_vid), 1);
            chk("vga.first_pixel_x", int'(vg_px), 0);
         end
         if (n == 640) chk("vga.pixel_x_639", int'(vg_px), 639);
         if (n == 641) begin
            chk("vga.video_off_640", int'(vg_vid), 0);
            chk("vga.pixel_x_blank", int'(vg_px), 0);
         end
         if (n == 801) begin
            chk("vga.line_start_801", int'(vg_ls), 1);
            chk("vga.pixel_y_line1", int'(vg_py), 1);
         end
         if (n == 1057) chk("svga.line_start_1057", int'(sv_ls), 1);
         if (n <= 800 && vg_hs == 1'b0) begin
            if (hs_first < 0) hs_first = n;
            hs_cnt++;
         end
         if (n <= 1056 && sv_hs == 1'b1) begin
            if (sv_first < 0) sv_first = n;
            sv_cnt++;
         end
      end
      chk("vga.hsync_first_adv", hs_first, 657);
      chk("vga.hsync_width", hs_cnt, 96);
      chk("svga.hsync_first_adv", sv_first, 841);
      chk("svga.hsync_width", sv_cnt, 128);

      // Asynchronous reset in the middle of an hsync pulse
      step(1'b1, 1'b0);
      for (int n = 1; n <= 700; n++) step(1'b1, 1'b1);
      chk("vga.in_hsync_before_clr", int'(vg_hs), 0);
      #2 clr_n = 1'b0;
      #1;
      chk("vga.async_hsync", int'(vg_hs), 1);
      chk("vga.async_video_on", int'(vg_vid), 0);
      chk("vga.async_pixel_x", int'(vg_px), 0);
      chk("svga.async_pixel_x", int'(sv_px), 0);
      chk("small.async_frame_cnt", int'(sm_fc), 0);
      model_reset();
      for (int d = 0; d < 3; d++) check_dut(d);
      @(negedge clk);
      clr_n = 1'b1;

      // ce pulsed 1-in-4: 100 advances over 400 clks
      sm_ls_cnt = 0;
      vg_ls_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         step((i % 4) == 0, 1'b1);
         sm_ls_cnt += int'(sm_ls);
         vg_ls_cnt += int'(vg_ls);
      end
      chk("vga.ce4_pixel_x", int'(vg_px), 99);
      chk("vga.ce4_line_strobes", vg_ls_cnt, 1);
      chk("small.ce4_line_strobes", sm_ls_cnt, 7);

      // Stop at small-mode pixel (5,2), then restart
      step(1'b1, 1'b0);
      for (int n = 1; n <= 36; n++) step(1'b1, 1'b1);
      chk("small.stop_pos_x", int'(sm_px), 5);
      chk("small.stop_pos_y", int'(sm_py), 2);
      f_saved = m_fc[0];
      step(1'b1, 1'b0);
      chk("small.stopped_video_on", int'(sm_vid), 0);
      chk("small.stopped_hsync", int'(sm_hs), 0);
      chk("small.stopped_vsync", int'(sm_vs), 1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("small.restart_frame_start", int'(sm_fs), 1);
      chk("small.restart_pixel_x", int'(sm_px), 0);
      chk("small.restart_video_on", int'(sm_vid), 1);
      chk("small.restart_frame_cnt", int'(sm_fc), f_saved);

      // Eight complete small frames: the 3-bit count must wrap exactly once
      wraps   = 0;
      prev_fc = int'(sm_fc);
      for (int n = 0; n < 965; n++) begin
         step(1'b1, 1'b1);
         if (prev_fc == 7 && sm_fc == 3'd0) wraps++;
         prev_fc = int'(sm_fc);
      end
      chk("small.frame_cnt_wraps", wraps, 1);
      chk("small.frame_cnt_8frames", int'(sm_fc), f_saved);

      // Randomised ce/en against the model
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 controller. It supports any mode through porch/sync/active parameters, programmable sync polarity, a pixel clock-enable instead of a dedicated pixel clock, and a run/stop control. It also provides registered glitch-free outputs and line/frame strobes. It sits between the pixel-clock divider and the display pixel source, whose pixel_x/pixel_y drive framebuffer or character-ROM addressing.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixel periods
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- CW, 10, counter and pixel coordinate width
- FRAME_W, 8, frame counter width
- clk  in  1  system clock
- clr_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- ce  in  1  pixel clock-enable; the raster advances one pixel per clk with ce=1
- en  in  1  run enable; 0 = stopped and blanked
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- video_on  out  1  current pixel is inside the active area
- pixel_x  out  CW  active-area column, 0..H_ACTIVE-1; 0 when not video_on
- pixel_y  out  CW  active-area row, 0..V_ACTIVE-1; 0 when not video_on
- line_start  out  1  one-clk strobe, first pixel of each line
- frame_start  out  1  one-clk strobe, first pixel of each frame
- frame_cnt  out  FRAME_W  completed-frame count, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way. Elaboration error if either total exceeds 2^CW or any parameter is 0.
- Horizontal counter hc runs 0..H_TOTAL-1. Region order: active [0, H_ACTIVE), front porch, sync, back porch.
- hsync is asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vertical counter vc runs 0..V_TOTAL-1 in the same region order and advances only when hc wraps.
- vsync is asserted for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- video_on = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Idle position is (H_TOTAL-1, V_TOTAL-1). Reset and en=0 both force the idle position, so the next advance lands on (0,0).
- Advance condition: ce=1 and en=1. Each advance steps hc; wrap to 0 steps vc; vc wrap to 0 increments frame_cnt modulo 2^FRAME_W.
- line_start is 1 for the single clk following an advance onto hc=0. frame_start is the same for (0,0). Both clear on the next clk regardless of ce.
- en=0 (takes priority over simultaneous ce):
  - counters go to the idle position synchronously;
  - hsync/vsync are deasserted; video_on, pixel_x, pixel_y and the strobes are 0;
  - frame_cnt is held.
- en 0→1: the first advance produces frame_start, line_start, video_on=1, pixel (0,0).

## Timing
- Reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL;
  - video_on = 0, pixel_x = pixel_y = 0;
  - line_start = frame_start = 0, frame_cnt = 0;
  - counters at the idle position.
- All outputs are registered, computed from next-state counter values. They change on the same clk edge as the counter advance, with zero latency relative to the raster position and no combinational path from inputs to outputs.
- With ce=0, all outputs hold except the strobes, which drop after one clk.
- Reset asserted mid-line: immediate async return to reset values. Release behaves like en 0→1.
- ce tied high gives one pixel per clk. The 640x480 default gives an 800x525 raster, 420000 advances per frame.

## Structure
- Package vga_timing_pkg holds:
  - parameter sets for 640x480@60 (above) and 800x600@60 (40/128/88 H; 1/4/23 V; positive polarity);
  - a function computing a region total from its four parameters.
- Sub-module vga_axis_counter (parameters TOTAL, ACTIVE, FP, SYNC, POL, CW):
  - inputs tick, stop;
  - outputs count, wrap, active, sync_next;
  - instantiated once for H (tick = ce&en) and once for V (tick = H wrap).

## Test plan
- Reset, then ce=1, en=1: first edge gives frame_start=line_start=1, video_on=1, pixel (0,0). After 639 more advances pixel_x=639; the next advance gives video_on=0, pixel_x=0.
- Defaults: hsync low for exactly 96 advances starting at hc=656. vsync low for exactly 2 lines starting at vc=490. line_start every 800 advances; frame_start every 420000.
- ce pulsed 1-in-4: pixel_x steps once per 4 clk. Strobes stay one clk wide. Raster content is identical to the ce=1 run.
- en dropped at pixel (100,50): next edge is blanked with syncs deasserted. After en returns, the first advance gives frame_start and pixel (0,0); frame_cnt is unchanged by the stop.
- clr_n asserted mid-hsync: outputs take reset values asynchronously, before any clk edge.
- 800x600 positive-polarity set with CW=11: hsync high at hc 840..967, H_TOTAL=1056, V_TOTAL=628. frame_cnt wraps 255→0 after 256 frames with FRAME_W=8.
